// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core DMA engine: transfer direction,
// DMEM request bundle, FSM states and an address-width helper.
package bsg_vanilla_pkg;

    typedef enum logic {
        DMA_PULL = 1'b0,
        DMA_PUSH = 1'b1
    } dma_dir_e;

    typedef enum logic [1:0] {
        DMA_LOCAL_IDLE = 2'd0,
        DMA_LOCAL_PUSH = 2'd1,
        DMA_LOCAL_PULL = 2'd2
    } dma_local_state_e;

    typedef struct packed {
        logic        w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } dmem_req_s;

    localparam int dma_word_bytes_gp = 4;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO, one write and one read port.
// Ports: v_i/data_i/ready_o enqueue side; v_o/data_o/yumi_i dequeue side.
module bsg_fifo_1r1w_small
    import bsg_vanilla_pkg::*;
#(
    parameter int els_p   = 2,
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                enq, deq;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign v_o     = (cnt_q != '0);
    assign ready_o = (cnt_q != cnt_w_lp'(els_p)) | yumi_i;
    assign deq     = yumi_i & v_o;
    assign enq     = v_i & ready_o;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        rptr_d = deq ? bump(rptr_q) : rptr_q;
        wptr_d = enq ? bump(wptr_q) : wptr_q;
        cnt_d  = cnt_q;
        if (enq && !deq) begin
            cnt_d = cnt_q + 1'b1;
        end else if (deq && !enq) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/dma_local_req_gen_fsm.sv
// DMA local request generator: owns the DMEM side of a transfer.
// PUSH reads DMEM words into a FIFO drained by the remote request generator;
// PULL writes in-order remote load responses into DMEM.
// Ports: start/dir/ptr/length in, ptr increment and done out, DMEM
// request/grant, PUSH FIFO head, remote response handshake.
module dma_local_req_gen_fsm
    import bsg_vanilla_pkg::*;
#(
    parameter  int data_width_p       = 32,
    parameter  int dmem_size_p        = 1024,
    parameter  int fifo_els_p         = 2,
    localparam int dmem_addr_width_lp = safe_clog2(dmem_size_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_local_req_i,
    input  logic                          push_not_pull_i,
    input  logic [31:0]                   local_ptr_i,
    input  logic [11:0]                   num_bytes_i,
    output logic                          incr_local_ptr_o,
    output logic                          all_local_req_done_o,
    output logic                          dmem_v_o,
    output logic                          dmem_w_o,
    output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
    output logic [data_width_p-1:0]       dmem_data_o,
    output logic [3:0]                    dmem_mask_o,
    input  logic                          dmem_yumi_i,
    input  logic [data_width_p-1:0]       dmem_data_i,
    output logic [data_width_p-1:0]       dmem_fifo_data_o,
    output logic                          dmem_fifo_v_o,
    input  logic                          dmem_fifo_yumi_i,
    input  logic                          remote_resp_v_i,
    input  logic [data_width_p-1:0]       remote_resp_data_i,
    output logic                          remote_resp_yumi_o
);

    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    dma_local_state_e    state_q, state_d;
    logic [31:0]         last_addr_q, last_addr_d;
    logic                inflight_q, inflight_d;
    logic [cnt_w_lp-1:0] occ_q, occ_d;
    logic [cnt_w_lp:0]   committed;

    dmem_req_s              req;
    logic                   req_v;
    logic                   at_end;
    logic                   credit;
    logic                   fifo_v;
    logic                   fifo_deq;
    logic                   fifo_ready;
    logic [data_width_p-1:0] fifo_data;
    logic                   unused_bits;

    assign at_end   = (local_ptr_i == last_addr_q);
    assign fifo_deq = dmem_fifo_yumi_i & fifo_v & ~reset_i;

    // Slots already owned: buffered words plus the read in flight, less
    // the word leaving this cycle so a steady stream never stalls.
    assign committed = {1'b0, occ_q}
                     + (cnt_w_lp + 1)'(inflight_q)
                     - (cnt_w_lp + 1)'(fifo_deq);
    assign credit    = committed < (cnt_w_lp + 1)'(fifo_els_p);

    bsg_fifo_1r1w_small #(
        .els_p   (fifo_els_p),
        .width_p (data_width_p)
    ) push_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (inflight_q),
        .data_i  (dmem_data_i),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_deq)
    );

    always_comb begin
        state_d              = state_q;
        last_addr_d          = last_addr_q;
        inflight_d           = 1'b0;
        occ_d                = occ_q;
        req                  = '0;
        req.addr             = {2'b00, local_ptr_i[31:2]};
        req.mask             = 4'hF;
        req_v                = 1'b0;
        incr_local_ptr_o     = 1'b0;
        all_local_req_done_o = 1'b0;
        remote_resp_yumi_o   = 1'b0;

        if (inflight_q && !fifo_deq) begin
            occ_d = occ_q + 1'b1;
        end else if (!inflight_q && fifo_deq) begin
            occ_d = occ_q - 1'b1;
        end

        if (!reset_i) begin
            unique case (state_q)
                DMA_LOCAL_IDLE: begin
                    if (start_local_req_i) begin
                        last_addr_d = local_ptr_i
                                    + {20'b0, num_bytes_i[11:2], 2'b00};
                        state_d = (dma_dir_e'(push_not_pull_i) == DMA_PUSH)
                                ? DMA_LOCAL_PUSH : DMA_LOCAL_PULL;
                    end
                end
                DMA_LOCAL_PUSH: begin
                    req_v = !at_end && credit;
                    if (req_v && dmem_yumi_i) begin
                        incr_local_ptr_o = 1'b1;
                        inflight_d       = 1'b1;
                    end
                    if (at_end && !inflight_q && (occ_q == '0)) begin
                        all_local_req_done_o = 1'b1;
                        state_d              = DMA_LOCAL_IDLE;
                    end
                end
                DMA_LOCAL_PULL: begin
                    req_v    = remote_resp_v_i && !at_end;
                    req.w    = 1'b1;
                    req.data = remote_resp_data_i;
                    if (req_v && dmem_yumi_i) begin
                        incr_local_ptr_o   = 1'b1;
                        remote_resp_yumi_o = 1'b1;
                    end
                    if (at_end) begin
                        all_local_req_done_o = 1'b1;
                        state_d              = DMA_LOCAL_IDLE;
                    end
                end
                default: state_d = DMA_LOCAL_IDLE;
            endcase
        end
    end

    assign dmem_v_o         = req_v;
    assign dmem_w_o         = req_v & req.w;
    assign dmem_addr_o      = req_v ? req.addr[dmem_addr_width_lp-1:0] : '0;
    assign dmem_data_o      = req_v ? req.data : '0;
    assign dmem_mask_o      = req_v ? req.mask : '0;
    assign dmem_fifo_v_o    = fifo_v & ~reset_i;
    assign dmem_fifo_data_o = dmem_fifo_v_o ? fifo_data : '0;

    assign unused_bits = ^{num_bytes_i[1:0],
                           req.addr[31:dmem_addr_width_lp],
                           fifo_ready};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= DMA_LOCAL_IDLE;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
        end
    end

    a_no_pop_when_empty: assert property (
        @(posedge clk_i) disable iff (reset_i)
        dmem_fifo_yumi_i |-> dmem_fifo_v_o
    );

endmodule

// File: tb/tb_dma_local_req_gen_fsm.sv
// Self-checking bench for dma_local_req_gen_fsm.
// Models DMEM, the local pointer, the consumer and the remote responder.
module tb_dma_local_req_gen_fsm;

    localparam int ELS = 2;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_local_req_i;
    logic          push_not_pull_i;
    logic [31:0]   local_ptr_i;
    logic [11:0]   num_bytes_i;
    logic          incr_local_ptr_o;
    logic          all_local_req_done_o;
    logic          dmem_v_o;
    logic          dmem_w_o;
    logic [AW-1:0] dmem_addr_o;
    logic [31:0]   dmem_data_o;
    logic [3:0]    dmem_mask_o;
    logic          dmem_yumi_i;
    logic [31:0]   dmem_data_i;
    logic [31:0]   dmem_fifo_data_o;
    logic          dmem_fifo_v_o;
    logic          dmem_fifo_yumi_i;
    logic          remote_resp_v_i;
    logic [31:0]   remote_resp_data_i;
    logic          remote_resp_yumi_o;

    always #5 clk = ~clk;

    logic cons_ready;
    assign dmem_fifo_yumi_i = cons_ready & dmem_fifo_v_o;

    dma_local_req_gen_fsm #(
        .data_width_p (32),
        .dmem_size_p  (1024),
        .fifo_els_p   (ELS)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .start_local_req_i    (start_local_req_i),
        .push_not_pull_i      (push_not_pull_i),
        .local_ptr_i          (local_ptr_i),
        .num_bytes_i          (num_bytes_i),
        .incr_local_ptr_o     (incr_local_ptr_o),
        .all_local_req_done_o (all_local_req_done_o),
        .dmem_v_o             (dmem_v_o),
        .dmem_w_o             (dmem_w_o),
        .dmem_addr_o          (dmem_addr_o),
        .dmem_data_o          (dmem_data_o),
        .dmem_mask_o          (dmem_mask_o),
        .dmem_yumi_i          (dmem_yumi_i),
        .dmem_data_i          (dmem_data_i),
        .dmem_fifo_data_o     (dmem_fifo_data_o),
        .dmem_fifo_v_o        (dmem_fifo_v_o),
        .dmem_fifo_yumi_i     (dmem_fifo_yumi_i),
        .remote_resp_v_i      (remote_resp_v_i),
        .remote_resp_data_i   (remote_resp_data_i),
        .remote_resp_yumi_o   (remote_resp_yumi_o)
    );

    typedef struct {
        int          a;
        logic [31:0] d;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          exp_rd[$];
    logic [31:0] exp_fifo[$];
    wr_t         exp_wr[$];
    logic [31:0] resp_q[$];

    logic        grant_alt;
    int          stall_cnt;
    logic [31:0] end_ptr;
    int          n_reads, n_writes, n_v, n_stall_reads, done_cnt;
    int          first_rd_cyc, last_rd_cyc, start_cyc, done_cyc;
    int          first_addr;
    logic        stall_v_last;

    logic        s_incr, s_rd, s_resp_pop;
    logic [31:0] s_rd_addr;

    function automatic logic [31:0] memval(input int a);
        return 32'hD000_0000 ^ (a * 32'h0101);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        int   ea;
        wr_t  ew;
        logic [31:0] ed;
        @(negedge clk);
        s_incr     = incr_local_ptr_o;
        s_rd       = dmem_v_o && dmem_yumi_i && !dmem_w_o;
        s_rd_addr  = 32'(dmem_addr_o);
        s_resp_pop = remote_resp_yumi_o;
        check("incr_eq_grant", incr_local_ptr_o, dmem_v_o && dmem_yumi_i);
        check("resp_yumi_eq_wgrant", remote_resp_yumi_o,
              dmem_v_o && dmem_w_o && dmem_yumi_i);
        if (dmem_v_o) n_v++;
        if (!cons_ready) begin
            stall_v_last = dmem_v_o;
            if (s_rd) n_stall_reads++;
        end
        if (s_rd) begin
            if (n_reads == 0) begin
                first_rd_cyc = cyc;
                first_addr   = 32'(dmem_addr_o);
            end
            last_rd_cyc = cyc;
            n_reads++;
            ea = -1;
            if (exp_rd.size() != 0) ea = exp_rd.pop_front();
            check("rd_addr", 64'(dmem_addr_o), 64'(ea));
        end
        if (dmem_v_o && dmem_w_o && dmem_yumi_i) begin
            if (n_writes == 0) first_addr = 32'(dmem_addr_o);
            n_writes++;
            ew = '{a: -1, d: 32'hFFFF_FFFF};
            if (exp_wr.size() != 0) ew = exp_wr.pop_front();
            check("wr_addr", 64'(dmem_addr_o), 64'(ew.a));
            check("wr_data", dmem_data_o, ew.d);
            check("wr_mask", dmem_mask_o, 4'hF);
        end
        if (dmem_fifo_v_o && dmem_fifo_yumi_i) begin
            ed = 32'hFFFF_FFFF;
            if (exp_fifo.size() != 0) ed = exp_fifo.pop_front();
            check("fifo_data", dmem_fifo_data_o, ed);
        end
        if (all_local_req_done_o) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_drained",
                  exp_rd.size() + exp_fifo.size() + exp_wr.size(), 0);
            check("done_ptr", local_ptr_i, end_ptr);
        end
    endtask

    task automatic apply();
        @(posedge clk);
        #1;
        cyc++;
        start_local_req_i = 1'b0;
        if (s_incr) local_ptr_i = local_ptr_i + 32'd4;
        dmem_data_i = s_rd ? memval(int'(s_rd_addr)) : 32'hDEAD_BEEF;
        if (s_resp_pop && resp_q.size() != 0) void'(resp_q.pop_front());
        if (grant_alt) dmem_yumi_i = ~dmem_yumi_i;
        if (stall_cnt > 0) stall_cnt--;
        cons_ready = (stall_cnt == 0);
        remote_resp_v_i    = (resp_q.size() != 0);
        remote_resp_data_i = remote_resp_v_i ? resp_q[0] : 32'h0;
    endtask

    task automatic step();
        sample();
        apply();
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        s_incr = 1'b0;
        s_rd   = 1'b0;
        s_resp_pop = 1'b0;
        check(name, {incr_local_ptr_o, all_local_req_done_o, dmem_v_o,
                     dmem_w_o, dmem_addr_o, dmem_data_o, dmem_mask_o,
                     dmem_fifo_data_o, dmem_fifo_v_o, remote_resp_yumi_o},
              '0);
        check({name, "_fifo_v"}, dmem_fifo_v_o, 1'b0);
    endtask

    // Loads the expected DMEM traffic for one transfer and pulses start.
    task automatic start(input bit push, input logic [31:0] p,
                         input logic [11:0] nb, input int stall);
        int nw;
        nw = int'(nb[11:2]);
        n_reads = 0; n_writes = 0; n_v = 0; n_stall_reads = 0;
        done_cnt = 0; first_addr = -1; stall_v_last = 1'b0;
        end_ptr = p + {20'b0, nb[11:2], 2'b00};
        for (int i = 0; i < nw; i++) begin
            if (push) begin
                exp_rd.push_back(int'(p >> 2) + i);
                exp_fifo.push_back(memval(int'(p >> 2) + i));
            end else begin
                exp_wr.push_back('{a: int'(p >> 2) + i, d: resp_q[i]});
            end
        end
        local_ptr_i       = p;
        push_not_pull_i   = push;
        num_bytes_i       = nb;
        start_local_req_i = 1'b1;
        stall_cnt         = stall;
        cons_ready        = (stall == 0);
        start_cyc         = cyc;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt, 1);
        repeat (3) step();
        check("done_once", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1; start_local_req_i = 1'b0; push_not_pull_i = 1'b0;
        local_ptr_i = 32'h0; num_bytes_i = 12'h0; dmem_yumi_i = 1'b1;
        dmem_data_i = 32'h0; cons_ready = 1'b1; remote_resp_v_i = 1'b0;
        remote_resp_data_i = 32'h0; grant_alt = 1'b0; stall_cnt = 0;
        s_incr = 1'b0; s_rd = 1'b0; s_resp_pop = 1'b0; s_rd_addr = 32'h0;
        end_ptr = 32'h0;

        check_zero("reset_during");
        apply();
        reset_i = 1'b0;
        check_zero("reset_after");
        apply();

        // PUSH 16 bytes, grant and consumer always ready
        start(1'b1, 32'h100, 12'd16, 0);
        run_to_done(40);
        check("t1_first_addr", first_addr, 'h40);
        check("t1_reads", n_reads, 4);
        check("t1_read_span", last_rd_cyc - first_rd_cyc, 3);
        check("t1_done_lat", done_cyc - start_cyc, 7);

        // PUSH 16 bytes, consumer stalled 10 cycles
        start(1'b1, 32'h100, 12'd16, 10);
        run_to_done(60);
        check("t2_stall_reads", n_stall_reads, ELS);
        check("t2_stall_v_end", stall_v_last, 1'b0);
        check("t2_reads", n_reads, 4);

        // PULL 12 bytes, grant denied every other cycle, one extra response
        resp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        remote_resp_v_i    = 1'b1;
        remote_resp_data_i = resp_q[0];
        grant_alt = 1'b1;
        start(1'b0, 32'h20, 12'd12, 0);
        run_to_done(40);
        check("t3_writes", n_writes, 3);
        check("t3_first_addr", first_addr, 8);
        check("t3_extra_kept", resp_q.size(), 1);
        grant_alt = 1'b0;
        dmem_yumi_i = 1'b1;

        // zero-length PULL with a response pending
        start(1'b0, 32'h40, 12'd0, 0);
        run_to_done(10);
        check("t4_pull_lat", done_cyc - start_cyc, 1);
        check("t4_pull_no_v", n_v, 0);
        check("t4_pull_resp_kept", resp_q.size(), 1);
        resp_q = {};
        remote_resp_v_i = 1'b0;

        // zero-length PUSH
        start(1'b1, 32'h300, 12'd0, 0);
        run_to_done(10);
        check("t4_push_lat", done_cyc - start_cyc, 1);
        check("t4_push_no_v", n_v, 0);

        // 7 bytes rounds down to one word
        start(1'b1, 32'h200, 12'd7, 0);
        run_to_done(20);
        check("t5_reads", n_reads, 1);
        check("t5_addr", first_addr, 'h80);

        // reset mid-PUSH with the FIFO full
        start(1'b1, 32'h100, 12'd16, 100);
        repeat (6) step();
        check("t6_fifo_full_v", dmem_fifo_v_o, 1'b1);
        reset_i = 1'b1;
        check_zero("t6_rst_during");
        apply();
        reset_i = 1'b0;
        stall_cnt = 0;
        cons_ready = 1'b1;
        check_zero("t6_rst_after");
        check("t6_no_done", done_cnt, 0);
        apply();
        exp_rd = {};
        exp_fifo = {};
        start(1'b1, 32'h400, 12'd8, 0);
        run_to_done(30);
        check("t6_restart_reads", n_reads, 2);
        check("t6_restart_addr", first_addr, 'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_local_req_gen_fsm.md
Name: dma_local_req_gen_fsm

Overview:
- DMA-engine stage that owns the vcore-local DMEM side of a transfer; sits beside the remote request generator.
- PUSH: reads DMEM words at the local pointer and buffers them in a small FIFO. The remote request generator pops that FIFO and turns each word into a remote store.
- PULL: takes in-order remote load responses and writes each returned word into DMEM at the local pointer.
- Shares the DMEM port with the core through a grant handshake.

Parameters:
- data_width_p, 32, word width; only 32 is supported.
- dmem_size_p, 1024, DMEM depth in words.
- fifo_els_p, 2, depth of the PUSH output FIFO; must be at least 2.
- dmem_addr_width_lp (localparam), `BSG_SAFE_CLOG2(dmem_size_p), DMEM word-address width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- start_local_req_i  in  1  one-cycle start pulse; sampled only in IDLE.
- push_not_pull_i  in  1  1 = PUSH, 0 = PULL; sampled together with start.
- local_ptr_i  in  32  global local byte pointer (word aligned); owned outside this block.
- num_bytes_i  in  12  transfer length in bytes; bits [1:0] are ignored.
- incr_local_ptr_o  out  1  advance the local pointer by 4.
- all_local_req_done_o  out  1  one-cycle done pulse.
- dmem_v_o  out  1  DMEM request valid.
- dmem_w_o  out  1  1 = write, 0 = read.
- dmem_addr_o  out  dmem_addr_width_lp  word address, equal to local_ptr_i[dmem_addr_width_lp+1:2].
- dmem_data_o  out  32  write data.
- dmem_mask_o  out  4  byte mask; always 4'hF when writing.
- dmem_yumi_i  in  1  DMEM grant in the same cycle as the request.
- dmem_data_i  in  32  read data, valid exactly 1 cycle after a granted read.
- dmem_fifo_data_o  out  32  PUSH FIFO head data.
- dmem_fifo_v_o  out  1  PUSH FIFO not empty.
- dmem_fifo_yumi_i  in  1  consumer pops the FIFO head.
- remote_resp_v_i  in  1  remote load response valid (PULL).
- remote_resp_data_i  in  32  remote load response data.
- remote_resp_yumi_o  out  1  response consumed.

Behaviour:
- Clocking and reset: one clock, clk_i; reset_i is synchronous, active-high.
- Reset clears state to IDLE, last_addr_r to 0, inflight_r to 0, and flushes the FIFO.
- All outputs are 0 during and immediately after reset; dmem_fifo_v_o is 0.
- Reset mid-transfer abandons the transfer: no done pulse, FIFO contents lost.
- States:
  - IDLE → PUSH/PULL on start_local_req_i.
  - PUSH → IDLE when complete.
  - PULL → IDLE when complete.
- Start capture: last_addr_r = local_ptr_i + {num_bytes_i[11:2], 2'b00}, 32-bit add, wrap ignored.
- Start is ignored outside IDLE.
- Zero length: last_addr_r == local_ptr_i. The next cycle in PUSH/PULL pulses done and returns to IDLE with no DMEM traffic.
- PUSH:
  - Credit rule: occupancy + inflight_r < fifo_els_p.
  - If local_ptr_i != last_addr_r and credit is available, assert dmem_v_o with dmem_w_o = 0.
  - On dmem_yumi_i: incr_local_ptr_o = 1 and inflight_r is set.
  - Next cycle: dmem_data_i is enqueued and inflight_r is cleared. The FIFO can never overflow.
  - FIFO push and pop may occur in the same cycle, including when the FIFO is full or holds 1 element.
  - Complete when local_ptr_i == last_addr_r, inflight_r == 0 and the FIFO is empty. Done pulses in that cycle; go to IDLE.
- PULL:
  - If remote_resp_v_i and local_ptr_i != last_addr_r: dmem_v_o = 1, dmem_w_o = 1, dmem_data_o = remote_resp_data_i.
  - On dmem_yumi_i: remote_resp_yumi_o = 1 and incr_local_ptr_o = 1, in the same cycle.
  - Without a grant, the response is held (not consumed) and the request is retried.
  - Complete when local_ptr_i == last_addr_r; done pulses in that cycle.
  - Responses arriving after completion are not consumed (remote_resp_yumi_o = 0).
- Throughput: with fifo_els_p ≥ 2 and a continuous grant and consumer, PUSH reaches 1 word per cycle. PULL is 1 word per cycle.
- incr_local_ptr_o asserts only in a granted cycle, and local_ptr_i reflects the increment in the next cycle.
- Simulation only: an assertion fires if dmem_fifo_yumi_i is asserted while the FIFO is empty.

Decomposition:
- bsg_vanilla_pkg holds:
  - dma_dir_e {DMA_PULL = 0, DMA_PUSH = 1};
  - a dmem request struct {w, addr, data, mask};
  - dma_word_bytes_gp = 4.
- Sub-module: bsg_fifo_1r1w_small (els_p = fifo_els_p, width 32) for the PUSH buffer.
- The FSM, credit counter and pointer compare stay in this module.

Test Plan:
- PUSH 16 bytes at ptr 0x100, grant always, consumer always ready:
  - DMEM reads at word addresses 0x40–0x43 on 4 consecutive cycles;
  - FIFO outputs the same words in order;
  - done fires once, after the last word pops.
- PUSH 16 bytes with the consumer stalled 10 cycles:
  - exactly fifo_els_p reads are issued, then dmem_v_o = 0;
  - no overflow; the transfer resumes on pop and all 4 words are delivered in order.
- PULL 12 bytes at ptr 0x20, responses 0xA, 0xB, 0xC, with the grant denied every other cycle:
  - writes of 0xA/0xB/0xC to word addresses 8/9/10, mask F;
  - remote_resp_yumi_o is high only in granted cycles; then done.
- num_bytes = 0 in both directions → done 1 cycle after start, no dmem_v_o.
- num_bytes = 7 → treated as 4 bytes; exactly one DMEM access.
- Reset asserted mid-PUSH with a full FIFO:
  - next cycle all outputs are 0 and dmem_fifo_v_o = 0;
  - a new start then runs normally.
